ext_code_loader_8p: RTL and testbench

//  Writer side of the 8-slot x 32-bit external code store. Takes a burst of 1..8 codes

---
 rtl/ext_code_loader_8p.sv | 198 +++++++++++++++++++
 tb/tb_ext_code_loader_8p.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_code_loader_8p.sv
// ext_code_loader_8p: writer side of the 8-slot x 32-bit external code store.
// Accepts a burst of 1..8 host codes and programs them into store slots
// count-1 down to 0, then arms the playback index at count-1. Playback
// order therefore matches host order.
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iStart, iCount      burst start request and code count (1..8)
//   iCode_valid, iCode  host code stream; oCode_ready accept strobe
//   oSET_INDEX_FLAG/oSET_INDEX, oSET_CODE_FLAG/oSET_CODE  store write strobes
//   iDEBUG_STORGE       store readback of the current slot
//   oBusy, oDone, oErr  status
// Option: define EXT_CODE_LOADER_READBACK_EN to verify every slot write
// against iDEBUG_STORGE and abort on a mismatch.
module ext_code_loader_8p #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [3:0]  iCount,
    input  logic        iCode_valid,
    input  logic [31:0] iCode,
    output logic        oCode_ready,
    output logic        oSET_INDEX_FLAG,
    output logic [7:0]  oSET_INDEX,
    output logic        oSET_CODE_FLAG,
    output logic [31:0] oSET_CODE,
    input  logic [31:0] iDEBUG_STORGE,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr
);

    localparam int M1   = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int M2   = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int MAXC = (M2 > 3) ? M2 : 3;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PW_END = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GW_END = CW'(GAP_W - 1);
    localparam logic [CW-1:0] TO_END = CW'(TIMEOUT - 1);
`ifdef EXT_CODE_LOADER_READBACK_EN
    // Two settle cycles so the store's readback reflects the new write.
    localparam logic [CW-1:0] CK_END = CW'(2);
`else
    localparam logic [CW-1:0] CK_END = CW'(0);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_IDX_SU,
        S_IDX_HI,
        S_IDX_LO,
        S_CODE_HI,
        S_CODE_LO,
        S_CHECK,
        S_ARM_SU,
        S_ARM_HI,
        S_ARM_LO,
        S_DONE,
        S_ABORT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic [3:0]    count_q, count_d;
    logic [7:0]    idx_q, idx_d;
    logic [31:0]   code_q, code_d;
    logic          err_q, err_d;

    logic count_ok;
    logic rb_bad;

    assign count_ok = (iCount != 4'd0) && (iCount <= 4'd8);

`ifdef EXT_CODE_LOADER_READBACK_EN
    assign rb_bad = (iDEBUG_STORGE != code_q);
`else
    logic unused_dbg;
    assign unused_dbg = ^iDEBUG_STORGE;
    assign rb_bad     = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (iStart && count_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iCode_valid)          state_d = S_IDX_SU;
                else if (cnt_q == TO_END) state_d = S_ABORT;
            end
            S_IDX_SU: state_d = S_IDX_HI;
            S_IDX_HI: begin
                if (cnt_q == PW_END) state_d = S_IDX_LO;
            end
            S_IDX_LO: begin
                if (cnt_q == GW_END) state_d = S_CODE_HI;
            end
            S_CODE_HI: begin
                if (cnt_q == PW_END) state_d = S_CODE_LO;
            end
            S_CODE_LO: begin
                if (cnt_q == GW_END) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (cnt_q == CK_END) begin
                    if (rb_bad)              state_d = S_ABORT;
                    else if (slot_q == 3'd0) state_d = S_ARM_SU;
                    else                     state_d = S_WAIT;
                end
            end
            S_ARM_SU: state_d = S_ARM_HI;
            S_ARM_HI: begin
                if (cnt_q == PW_END) state_d = S_ARM_LO;
            end
            S_ARM_LO: begin
                if (cnt_q == GW_END) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        idx_d   = idx_q;
        code_d  = code_q;
        err_d   = err_q;
        // Phase counter restarts on every state change, so in WAIT it
        // counts consecutive cycles without host valid.
        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
        else                                          cnt_d = cnt_q + 1'b1;

        if (state_q == S_IDLE && iStart) begin
            err_d = !count_ok;
            if (count_ok) begin
                count_d = iCount;
                slot_d  = 3'(iCount - 4'd1);
            end
        end
        if (state_q == S_WAIT && iCode_valid) begin
            code_d = iCode;
            idx_d  = {5'd0, slot_q};
        end
        if (state_q == S_CHECK && state_d == S_WAIT) begin
            slot_d = slot_q - 3'd1;
        end
        if (state_q == S_CHECK && state_d == S_ARM_SU) begin
            idx_d = {4'd0, count_q - 4'd1};
        end
        if (state_d == S_ABORT) err_d = 1'b1;
    end

    // Outputs
    always_comb begin
        oCode_ready     = (state_q == S_WAIT) && iCode_valid;
        oSET_INDEX_FLAG = (state_q == S_IDX_HI) || (state_q == S_ARM_HI);
        oSET_CODE_FLAG  = (state_q == S_CODE_HI);
        oBusy           = (state_q != S_IDLE) && (state_q != S_DONE)
                       && (state_q != S_ABORT);
        oDone           = (state_q == S_DONE);
        oSET_INDEX      = idx_q;
        oSET_CODE       = code_q;
        oErr            = err_q;
    end

endmodule

// File: tb/tb_ext_code_loader_8p.sv
// Bench for ext_code_loader_8p with a behavioural model of the code store.
// Table-driven bursts plus hand sequences for timeout, reset and readback.
module tb_ext_code_loader_8p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cnt_in = 4'd0;
    logic        valid = 1'b0;
    logic [31:0] data = 32'd0;
    logic        rdy;
    logic        ifl;
    logic [7:0]  idx;
    logic        cfl;
    logic [31:0] code;
    logic [31:0] dbg;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_code_loader_8p #(
        .PULSE_W(2),
        .GAP_W  (2),
        .TIMEOUT(16)
    ) dut (
        .iClk           (clk),
        .iRst           (rst),
        .iStart         (start),
        .iCount         (cnt_in),
        .iCode_valid    (valid),
        .iCode          (data),
        .oCode_ready    (rdy),
        .oSET_INDEX_FLAG(ifl),
        .oSET_INDEX     (idx),
        .oSET_CODE_FLAG (cfl),
        .oSET_CODE      (code),
        .iDEBUG_STORGE  (dbg),
        .oBusy          (busy),
        .oDone          (done),
        .oErr           (err)
    );

    // Store model: index latched on index-flag rise, code written on code-flag rise.
    logic [31:0] mem [8];
    logic [2:0]  cur_idx = 3'd0;
    bit          corrupt = 1'b0;
    int n_idx = 0, n_code = 0, n_rdy = 0, n_done = 0, n_busy = 0, viol = 0;
    logic        p_if = 1'b0, p_cf = 1'b0;
    logic [7:0]  p_idx = 8'd0;
    logic [31:0] p_code = 32'd0;
    int w_i = 0, w_c = 0;

    assign dbg = mem[cur_idx] ^ ((corrupt && cur_idx == 3'd5) ? 32'h1 : 32'h0);

    always @(negedge clk) begin
        if (ifl && cfl) viol++;
        if ((ifl || cfl) && (p_if || p_cf) && (idx != p_idx || code != p_code)) viol++;
        if (ifl && !p_if) begin
            n_idx++;
            cur_idx = idx[2:0];
        end
        if (cfl && !p_cf) begin
            n_code++;
            mem[cur_idx] = code;
        end
        if (ifl) w_i++;
        else begin
            if (p_if && w_i != 2) viol++;
            w_i = 0;
        end
        if (cfl) w_c++;
        else begin
            if (p_cf && w_c != 2) viol++;
            w_c = 0;
        end
        if (rdy && valid) n_rdy++;
        if (done) n_done++;
        if (busy) n_busy++;
        p_if   = ifl;
        p_cf   = cfl;
        p_idx  = idx;
        p_code = code;
    end

    typedef struct {
        int          n;
        int          stall;
        logic [31:0] base;
        logic        exp_err;
        logic        exp_done;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] code_of(logic [31:0] base, int i);
        return base + 32'(i) * 32'h11;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(int n);
        start  = 1'b1;
        cnt_in = 4'(n);
        tick();
        start  = 1'b0;
    endtask

    task automatic send_one(logic [31:0] c, int stall);
        bit got;
        got = 1'b0;
        repeat (stall) tick();
        valid = 1'b1;
        data  = c;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (rdy) got = 1'b1;
            else tick();
        end
        tick();
        valid = 1'b0;
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_end(int maxc, output logic e);
        bit got;
        got = 1'b0;
        e   = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            @(negedge clk);
            if (done || err) begin
                got = 1'b1;
                e   = err;
            end
        end
        tick();
        if (!got) chk("end_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int s_idx, s_code, s_rdy, s_done, s_busy, s_viol;
        logic e;
        logic [2:0] p;

        vecs[0] = '{3, 0, 32'h0000_00A1, 1'b0, 1'b1};
        vecs[1] = '{8, 12, 32'h1000_0000, 1'b0, 1'b1};
        vecs[2] = '{0, 0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{9, 0, 32'h0, 1'b1, 1'b0};
        vecs[4] = '{1, 2, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[5] = '{15, 0, 32'h0, 1'b1, 1'b0};

        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {30'd0, ifl, cfl}, 32'd0);
        chk("rst_index", 32'(idx), 32'd0);
        chk("rst_code", code, 32'd0);
        chk("rst_err_done", {30'd0, err, done}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        for (int v = 0; v < 6; v++) begin
            s_idx = n_idx; s_code = n_code; s_rdy = n_rdy;
            s_done = n_done; s_busy = n_busy; s_viol = viol;
            if (vecs[v].exp_err) begin
                valid = 1'b1;
                data  = 32'h5555_AAAA;
                pulse_start(vecs[v].n);
                repeat (4) tick();
                @(negedge clk);
                chk($sformatf("v%0d_err", v), 32'(err), 32'd1);
                tick();
                valid = 1'b0;
                chk($sformatf("v%0d_busy", v), 32'(n_busy - s_busy), 32'd0);
                chk($sformatf("v%0d_edges", v), 32'(n_idx - s_idx + n_code - s_code), 32'd0);
                chk($sformatf("v%0d_rdy", v), 32'(n_rdy - s_rdy), 32'd0);
                chk($sformatf("v%0d_done", v), 32'(n_done - s_done), 32'd0);
            end else begin
                pulse_start(vecs[v].n);
                for (int i = 0; i < vecs[v].n; i++)
                    send_one(code_of(vecs[v].base, i), vecs[v].stall);
                wait_end(300, e);
                repeat (3) tick();
                chk($sformatf("v%0d_err", v), 32'(e), 32'd0);
                chk($sformatf("v%0d_done", v), 32'(n_done - s_done), 32'd1);
                chk($sformatf("v%0d_rdy", v), 32'(n_rdy - s_rdy), 32'(vecs[v].n));
                chk($sformatf("v%0d_idxp", v), 32'(n_idx - s_idx), 32'(vecs[v].n + 1));
                chk($sformatf("v%0d_codep", v), 32'(n_code - s_code), 32'(vecs[v].n));
                chk($sformatf("v%0d_viol", v), 32'(viol - s_viol), 32'd0);
                chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
                chk($sformatf("v%0d_arm", v), 32'(cur_idx), 32'(vecs[v].n - 1));
                p = cur_idx;
                for (int i = 0; i < vecs[v].n; i++) begin
                    chk($sformatf("v%0d_play%0d", v, i), mem[p], code_of(vecs[v].base, i));
                    p = p - 3'd1;
                end
            end
            repeat (2) tick();
        end

        // Timeout: one code then the host goes silent.
        s_idx = n_idx; s_code = n_code; s_done = n_done; s_busy = n_busy;
        pulse_start(4);
        send_one(32'h7777_0001, 0);
        wait_end(100, e);
        chk("to_err", 32'(e), 32'd1);
`ifdef EXT_CODE_LOADER_READBACK_EN
        chk("to_busy_cycles", 32'(n_busy - s_busy), 32'd29);
`else
        chk("to_busy_cycles", 32'(n_busy - s_busy), 32'd27);
`endif
        repeat (2) tick();
        chk("to_idxp", 32'(n_idx - s_idx), 32'd1);
        chk("to_codep", 32'(n_code - s_code), 32'd1);
        chk("to_done", 32'(n_done - s_done), 32'd0);
        chk("to_flags", {30'd0, ifl, cfl}, 32'd0);

        // Reset during the code pulse of slot 1.
        pulse_start(3);
        send_one(32'h0000_0011, 0);
        send_one(32'h0000_0022, 0);
        begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                if (cfl) got = 1'b1;
            end
            if (!got) chk("rst_seq_timeout", 32'd0, 32'd1);
        end
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_flags", {30'd0, ifl, cfl}, 32'd0);
        chk("mid_rst_outs", {29'd0, busy, done, err}, 32'd0);
        chk("mid_rst_index", 32'(idx), 32'd0);
        chk("mid_rst_code", code, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        s_done = n_done;
        pulse_start(1);
        pulse_start(0);
        send_one(32'h0BAD_F00D, 0);
        wait_end(100, e);
        repeat (2) tick();
        chk("post_rst_err", 32'(e), 32'd0);
        chk("post_rst_done", 32'(n_done - s_done), 32'd1);
        chk("post_rst_slot0", mem[0], 32'h0BAD_F00D);

`ifdef EXT_CODE_LOADER_READBACK_EN
        corrupt = 1'b1;
        s_idx = n_idx; s_code = n_code; s_done = n_done;
        pulse_start(8);
        for (int i = 0; i < 3; i++) send_one(32'hC0DE_0000 + 32'(i), 0);
        wait_end(100, e);
        repeat (2) tick();
        chk("rb_err", 32'(e), 32'd1);
        chk("rb_done", 32'(n_done - s_done), 32'd0);
        chk("rb_codep", 32'(n_code - s_code), 32'd3);
        chk("rb_idxp", 32'(n_idx - s_idx), 32'd3);
        corrupt = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
